// File: rtl/vote_if.sv
// vote_if: bundles ballot controls, candidate buttons, vote totals and status flags.
// Parameter:
//   COUNT_W   width of each vote total
// Signals (master drives, slave receives):
//   ballot_enable, mode, clear_counts, button_c1..button_c4   control and buttons
// Signals (slave drives, master receives):
//   vote_count_c1..vote_count_c4   registered vote totals
//   ballot_ready, vote_accepted, vote_index, invalid_press   ballot status
// Modports:
//   master   testbench or controller side
//   slave    vote logger side
interface vote_if #(parameter int COUNT_W = 8);
    logic               ballot_enable;
    logic               mode;
    logic               clear_counts;
    logic               button_c1;
    logic               button_c2;
    logic               button_c3;
    logic               button_c4;
    logic [COUNT_W-1:0] vote_count_c1;
    logic [COUNT_W-1:0] vote_count_c2;
    logic [COUNT_W-1:0] vote_count_c3;
    logic [COUNT_W-1:0] vote_count_c4;
    logic               ballot_ready;
    logic               vote_accepted;
    logic [2:0]         vote_index;
    logic               invalid_press;
    modport master (
        output ballot_enable, mode, clear_counts, button_c1, button_c2, button_c3, button_c4,
        input  vote_count_c1, vote_count_c2, vote_count_c3, vote_count_c4,
        input  ballot_ready, vote_accepted, vote_index, invalid_press
    );
    modport slave (
        input  ballot_enable, mode, clear_counts, button_c1, button_c2, button_c3, button_c4,
        output vote_count_c1, vote_count_c2, vote_count_c3, vote_count_c4,
        output ballot_ready, vote_accepted, vote_index, invalid_press
    );
endinterface

// File: rtl/vote_logger.sv
// vote_logger: arms one ballot at a time, debounces a single candidate press and keeps four saturating vote totals.
// Parameters:
//   DEBOUNCE_CYCLES   consecutive sampled-high cycles needed before a vote commits (>= 1)
//   COUNT_W           width of each vote total
// Ports:
//   clock_i     system clock, rising edge
//   reset_n_i   asynchronous active-low reset
//   bus         vote_if slave: controls and buttons in, totals and status out
module vote_logger #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8
) (
    input logic   clock_i,
    input logic   reset_n_i,
    vote_if.slave bus
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] ARMED        = 3'd1;
    localparam logic [2:0] DEBOUNCE     = 3'd2;
    localparam logic [2:0] COMMIT       = 3'd3;
    localparam logic [2:0] WAIT_RELEASE = 3'd4;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_N = DW'(DEBOUNCE_CYCLES);

    logic [2:0]         state_q, state_d;
    logic               ret_armed_q, ret_armed_d;
    logic [1:0]         idx_q, idx_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [COUNT_W-1:0] count_q [4];
    logic [COUNT_W-1:0] count_d [4];
    logic [2:0]         vote_index_q, vote_index_d;
    logic               ready_q, ready_d;
    logic               accepted_q;
    logic               invalid_q, invalid_d;
    logic               clr;
    logic [3:0]         btn;
    logic               multi;
    logic               hit;
    logic               others;

    assign btn    = {bus.button_c4, bus.button_c3, bus.button_c2, bus.button_c1};
    assign multi  = (btn & (btn - 4'd1)) != 4'd0;
    assign hit    = btn[idx_q];
    assign others = (btn & ~(4'd1 << idx_q)) != 4'd0;
    // clear is honoured in IDLE even in result mode
    assign clr    = (state_q == IDLE) && bus.clear_counts;

    always_comb begin
        state_d     = state_q;
        ret_armed_d = ret_armed_q;
        idx_d       = idx_q;
        dcnt_d      = dcnt_q;
        invalid_d   = 1'b0;
        if (state_q == COMMIT) begin
            // a commit in progress always completes; result mode only skips the release wait
            ret_armed_d = 1'b0;
            state_d     = bus.mode ? IDLE : WAIT_RELEASE;
        end else if (bus.mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = (!bus.clear_counts && bus.ballot_enable) ? ARMED : IDLE;
                ARMED: begin
                    if (multi) begin
                        invalid_d   = 1'b1;
                        ret_armed_d = 1'b1;
                        state_d     = WAIT_RELEASE;
                    end else if (btn != 4'd0) begin
                        idx_d   = btn[0] ? 2'd0 : btn[1] ? 2'd1 : btn[2] ? 2'd2 : 2'd3;
                        dcnt_d  = DW'(1);
                        state_d = (DEBOUNCE_CYCLES == 1) ? COMMIT : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (others) begin
                        invalid_d   = 1'b1;
                        ret_armed_d = 1'b1;
                        state_d     = WAIT_RELEASE;
                    end else if (!hit) begin
                        state_d = ARMED;
                    end else begin
                        dcnt_d  = dcnt_q + DW'(1);
                        state_d = (dcnt_d == DEB_N) ? COMMIT : DEBOUNCE;
                    end
                end
                WAIT_RELEASE: state_d = (btn == 4'd0) ? (ret_armed_q ? ARMED : IDLE) : WAIT_RELEASE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_d[i] = clr ? '0 : count_q[i];
        end
        // the increment lands at the closing edge of COMMIT and saturates
        if (state_q == COMMIT && count_q[idx_q] != {COUNT_W{1'b1}}) begin
            count_d[idx_q] = count_q[idx_q] + COUNT_W'(1);
        end
        vote_index_d = clr ? 3'd0 : (state_d == COMMIT) ? {1'b0, idx_d} + 3'd1 : vote_index_q;
        ready_d      = (state_d == ARMED) || (state_d == DEBOUNCE) ||
                       (state_d == WAIT_RELEASE && ret_armed_d);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            ret_armed_q  <= 1'b0;
            idx_q        <= 2'd0;
            dcnt_q       <= '0;
            vote_index_q <= 3'd0;
            ready_q      <= 1'b0;
            accepted_q   <= 1'b0;
            invalid_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ret_armed_q  <= ret_armed_d;
            idx_q        <= idx_d;
            dcnt_q       <= dcnt_d;
            vote_index_q <= vote_index_d;
            ready_q      <= ready_d;
            accepted_q   <= (state_d == COMMIT);
            invalid_q    <= invalid_d;
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign bus.vote_count_c1 = count_q[0];
    assign bus.vote_count_c2 = count_q[1];
    assign bus.vote_count_c3 = count_q[2];
    assign bus.vote_count_c4 = count_q[3];
    assign bus.ballot_ready  = ready_q;
    assign bus.vote_accepted = accepted_q;
    assign bus.vote_index    = vote_index_q;
    assign bus.invalid_press = invalid_q;
endmodule

// File: tb/tb_vote_logger.sv
// tb_vote_logger: directed scenarios for vote_logger with hand-computed expectations.
module tb_vote_logger;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   acc_cnt;
    int   inv_cnt;
    int   a0;
    int   i0;

    vote_if #(.COUNT_W(8)) bus ();

    vote_logger #(.DEBOUNCE_CYCLES(4), .COUNT_W(8)) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.vote_accepted) acc_cnt++;
        if (bus.invalid_press) inv_cnt++;
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {bus.button_c4, bus.button_c3, bus.button_c2, bus.button_c1} = b;
    endtask

    task automatic arm();
        bus.ballot_enable = 1'b1;
        tick();
        bus.ballot_enable = 1'b0;
    endtask

    task automatic do_vote(input logic [3:0] b);
        arm();
        set_btn(b);
        tick(5);
        set_btn(4'b0000);
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if ({bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4} !== 32'd0) begin bad++; $display("FAIL reset_counts: got %h want 0", {bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4}); end
        total++; if ({bus.ballot_ready, bus.vote_accepted, bus.invalid_press, bus.vote_index} !== 6'd0) begin bad++; $display("FAIL reset_flags: got %b want 000000", {bus.ballot_ready, bus.vote_accepted, bus.invalid_press, bus.vote_index}); end
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vote_c2();
        a0 = acc_cnt;
        arm();
        total++; if (bus.ballot_ready !== 1'b1) begin bad++; $display("FAIL c2_ready_armed: got %b want 1", bus.ballot_ready); end
        set_btn(4'b0010);
        tick(4);
        total++; if ({bus.vote_accepted, bus.vote_index, bus.vote_count_c2} !== {1'b1, 3'd2, 8'd0}) begin bad++; $display("FAIL c2_commit_cycle: got acc=%b idx=%0d c2=%0d want acc=1 idx=2 c2=0", bus.vote_accepted, bus.vote_index, bus.vote_count_c2); end
        tick();
        total++; if ({bus.vote_accepted, bus.vote_count_c2} !== {1'b0, 8'd1}) begin bad++; $display("FAIL c2_after_commit: got acc=%b c2=%0d want acc=0 c2=1", bus.vote_accepted, bus.vote_count_c2); end
        tick();
        set_btn(4'b0000);
        tick(2);
        total++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL c2_pulses: got %0d want 1", acc_cnt - a0); end
        total++; if ({bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4} !== {8'd0, 8'd1, 8'd0, 8'd0}) begin bad++; $display("FAIL c2_counts: got %h want 00010000", {bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4}); end
        total++; if ({bus.ballot_ready, bus.vote_index} !== {1'b0, 3'd2}) begin bad++; $display("FAIL c2_released: got ready=%b idx=%0d want ready=0 idx=2", bus.ballot_ready, bus.vote_index); end
    endtask

    task automatic test_short_press();
        a0 = acc_cnt;
        arm();
        set_btn(4'b0001);
        tick(2);
        set_btn(4'b0000);
        tick(2);
        total++; if ({bus.ballot_ready, bus.vote_count_c1} !== {1'b1, 8'd0}) begin bad++; $display("FAIL short_bounce: got ready=%b c1=%0d want ready=1 c1=0", bus.ballot_ready, bus.vote_count_c1); end
        total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL short_no_pulse: got %0d want 0", acc_cnt - a0); end
        set_btn(4'b0001);
        tick(5);
        set_btn(4'b0000);
        tick(2);
        total++; if ({bus.vote_count_c1, bus.vote_index, bus.ballot_ready} !== {8'd1, 3'd1, 1'b0}) begin bad++; $display("FAIL short_then_vote: got c1=%0d idx=%0d ready=%b want c1=1 idx=1 ready=0", bus.vote_count_c1, bus.vote_index, bus.ballot_ready); end
    endtask

    task automatic test_invalid();
        i0 = inv_cnt;
        a0 = acc_cnt;
        arm();
        set_btn(4'b0101);
        tick(2);
        total++; if ({bus.ballot_ready, bus.invalid_press} !== 2'b10) begin bad++; $display("FAIL inv_wait: got ready=%b inv=%b want ready=1 inv=0", bus.ballot_ready, bus.invalid_press); end
        total++; if (inv_cnt - i0 !== 1) begin bad++; $display("FAIL inv_pulse_once: got %0d want 1", inv_cnt - i0); end
        set_btn(4'b0000);
        tick();
        set_btn(4'b0100);
        tick(2);
        set_btn(4'b0101);
        tick();
        set_btn(4'b0000);
        tick();
        total++; if (inv_cnt - i0 !== 2) begin bad++; $display("FAIL inv_in_debounce: got %0d want 2", inv_cnt - i0); end
        set_btn(4'b0100);
        tick(5);
        set_btn(4'b0000);
        tick(2);
        total++; if ({bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4} !== {8'd1, 8'd1, 8'd1, 8'd0}) begin bad++; $display("FAIL inv_then_c3: got %h want 01010100", {bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4}); end
        total++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL inv_accept_count: got %0d want 1", acc_cnt - a0); end
    endtask

    task automatic test_commit_mode();
        arm();
        set_btn(4'b0001);
        tick(4);
        bus.mode = 1'b1;
        tick();
        bus.mode = 1'b0;
        total++; if ({bus.vote_count_c1, bus.ballot_ready} !== {8'd2, 1'b0}) begin bad++; $display("FAIL commit_mode_done: got c1=%0d ready=%b want c1=2 ready=0", bus.vote_count_c1, bus.ballot_ready); end
        arm();
        total++; if (bus.ballot_ready !== 1'b1) begin bad++; $display("FAIL commit_mode_idle: got ready=%b want 1", bus.ballot_ready); end
        set_btn(4'b0000);
        bus.mode = 1'b1;
        tick();
        bus.mode = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 255; n++) do_vote(4'b1000);
        total++; if (bus.vote_count_c4 !== 8'd255) begin bad++; $display("FAIL sat_preload: got %0d want 255", bus.vote_count_c4); end
        a0 = acc_cnt;
        do_vote(4'b1000);
        total++; if ({bus.vote_count_c4, bus.vote_index} !== {8'd255, 3'd4}) begin bad++; $display("FAIL sat_hold: got c4=%0d idx=%0d want c4=255 idx=4", bus.vote_count_c4, bus.vote_index); end
        total++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL sat_pulse: got %0d want 1", acc_cnt - a0); end
    endtask

    task automatic test_abort_clear();
        a0 = acc_cnt;
        arm();
        set_btn(4'b0010);
        tick(2);
        bus.mode = 1'b1;
        tick();
        total++; if (bus.ballot_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus.ballot_ready); end
        tick(4);
        set_btn(4'b0000);
        bus.ballot_enable = 1'b1;
        tick();
        bus.ballot_enable = 1'b0;
        tick();
        total++; if ({bus.ballot_ready, bus.vote_count_c2} !== {1'b0, 8'd1}) begin bad++; $display("FAIL abort_enable_ignored: got ready=%b c2=%0d want ready=0 c2=1", bus.ballot_ready, bus.vote_count_c2); end
        total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL abort_no_pulse: got %0d want 0", acc_cnt - a0); end
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        bus.mode = 1'b0;
        total++; if ({bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4, bus.vote_index} !== 35'd0) begin bad++; $display("FAIL clear_all: got %h idx=%0d want 0", {bus.vote_count_c1, bus.vote_count_c2, bus.vote_count_c3, bus.vote_count_c4}, bus.vote_index); end
        bus.clear_counts = 1'b1;
        bus.ballot_enable = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        bus.ballot_enable = 1'b0;
        tick();
        total++; if (bus.ballot_ready !== 1'b0) begin bad++; $display("FAIL clear_beats_enable: got ready=%b want 0", bus.ballot_ready); end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 3; n++) do_vote(4'b0001);
        total++; if (bus.vote_count_c1 !== 8'd3) begin bad++; $display("FAIL rmid_preload: got %0d want 3", bus.vote_count_c1); end
        a0 = acc_cnt;
        arm();
        set_btn(4'b0001);
        tick(2);
        rst_n = 1'b0;
        #1;
        total++; if ({bus.vote_count_c1, bus.ballot_ready} !== {8'd0, 1'b0}) begin bad++; $display("FAIL rmid_async: got c1=%0d ready=%b want c1=0 ready=0", bus.vote_count_c1, bus.ballot_ready); end
        tick();
        rst_n = 1'b1;
        tick(6);
        set_btn(4'b0000);
        tick();
        total++; if ({bus.vote_count_c1, bus.ballot_ready, bus.vote_index} !== {8'd0, 1'b0, 3'd0}) begin bad++; $display("FAIL rmid_needs_arm: got c1=%0d ready=%b idx=%0d want 0 0 0", bus.vote_count_c1, bus.ballot_ready, bus.vote_index); end
        total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL rmid_no_pulse: got %0d want 0", acc_cnt - a0); end
        do_vote(4'b0001);
        total++; if ({bus.vote_count_c1, bus.vote_index} !== {8'd1, 3'd1}) begin bad++; $display("FAIL rmid_revote: got c1=%0d idx=%0d want c1=1 idx=1", bus.vote_count_c1, bus.vote_index); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        acc_cnt = 0;
        inv_cnt = 0;
        rst_n = 1'b0;
        bus.ballot_enable = 1'b0;
        bus.mode = 1'b0;
        bus.clear_counts = 1'b0;
        set_btn(4'b0000);
        test_reset();
        test_vote_c2();
        test_short_press();
        test_invalid();
        test_commit_mode();
        test_saturate();
        test_abort_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
